huff_code_gen: RTL and testbench

Canonical Huffman code generator for the encode path. It sits directly downstream of the per-symbol code-length register file and reads it through that file's combinational read port (addr in, dout out, write enable held low by the upstream writer while this block is busy). It histograms the lengths, derives the first code for each length, and streams one (symbol, code, length) record per used symbol, in ascending symbol order, to the code-table writer.

---
 rtl/huff_pkg.sv | 26 ++
 rtl/huff_len_hist.sv | 54 +++++
 rtl/huff_code_gen.sv | 211 +++++++++++++++++++++
 tb/tb_huff_code_gen.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/huff_pkg.sv
//------------------------------------------------------------------------------
// huff_pkg : shared defaults, derived widths and FSM states for huff_code_gen
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package huff_pkg;

    localparam int DEF_LEN_WIDTH = 6;
    localparam int DEF_SYM_NUM   = 256;
    localparam int DEF_MAX_LEN   = 16;

    localparam int SYM_AW = $clog2(DEF_SYM_NUM);
    localparam int CNT_W  = SYM_AW + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        COUNT  = 3'd1,
        GEN    = 3'd2,
        ASSIGN = 3'd3,
        DONE   = 3'd4
    } huff_cg_state_t;

endpackage

`default_nettype wire

// File: rtl/huff_len_hist.sv
//------------------------------------------------------------------------------
// huff_len_hist : per-length symbol histogram (bl_count) with clear/increment
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module huff_len_hist
    import huff_pkg::*;
#(
    parameter int LEN_WIDTH = DEF_LEN_WIDTH,
    parameter int MAX_LEN   = DEF_MAX_LEN,
    parameter int BIN_W     = CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 inc_i,
    input  logic [LEN_WIDTH-1:0] inc_len_i,
    input  logic [LEN_WIDTH-1:0] rd_len_i,
    output logic [BIN_W-1:0]     rd_cnt_o,
    output logic [BIN_W-1:0]     top_cnt_o
);

    // Bin 0 is never stored: unused symbols do not count, and it reads as 0.
    logic [BIN_W-1:0] bl_count_q [1:MAX_LEN];

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            for (int i = 1; i <= MAX_LEN; i++) begin
                bl_count_q[i] <= '0;
            end
        end else if (inc_i) begin
            for (int i = 1; i <= MAX_LEN; i++) begin
                if (inc_len_i == LEN_WIDTH'(i)) begin
                    bl_count_q[i] <= bl_count_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_cnt_o = '0;
        for (int i = 1; i <= MAX_LEN; i++) begin
            if (rd_len_i == LEN_WIDTH'(i)) begin
                rd_cnt_o = bl_count_q[i];
            end
        end
    end

    assign top_cnt_o = bl_count_q[MAX_LEN];

endmodule

`default_nettype wire

// File: rtl/huff_code_gen.sv
//------------------------------------------------------------------------------
// huff_code_gen : canonical Huffman code generator (histogram, first codes,
//                 per-symbol record stream with valid/ready handshake)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module huff_code_gen
    import huff_pkg::*;
#(
    parameter int LEN_WIDTH = DEF_LEN_WIDTH,
    parameter int SYM_NUM   = DEF_SYM_NUM,
    parameter int MAX_LEN   = DEF_MAX_LEN,
    localparam int ADDR_W   = $clog2(SYM_NUM),
    localparam int BIN_W    = ADDR_W + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [ADDR_W-1:0]    len_addr_o,
    input  logic [LEN_WIDTH-1:0] len_din_i,
    output logic                 code_valid_o,
    input  logic                 code_ready_i,
    output logic [ADDR_W-1:0]    code_sym_o,
    output logic [MAX_LEN-1:0]   code_o,
    output logic [LEN_WIDTH-1:0] code_len_o
);

    localparam logic [ADDR_W-1:0]    LAST_ADDR = ADDR_W'(SYM_NUM - 1);
    localparam logic [LEN_WIDTH-1:0] MAX_LEN_L = LEN_WIDTH'(MAX_LEN);
    localparam logic [MAX_LEN+1:0]   KRAFT_LIM = (MAX_LEN + 2)'(1) << MAX_LEN;

    huff_cg_state_t       state_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [LEN_WIDTH-1:0] k_q;
    logic [MAX_LEN:0]     acc_q;
    logic [MAX_LEN:0]     acc_d;
    logic                 bad_len_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;
    logic                 valid_q;
    logic [ADDR_W-1:0]    sym_q;
    logic [MAX_LEN-1:0]   code_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [MAX_LEN:0]     next_code_q [1:MAX_LEN];

    logic [BIN_W-1:0]     gen_cnt;
    logic [BIN_W-1:0]     top_cnt;
    logic [MAX_LEN+1:0]   kraft_sum;
    logic                 oversub;
    logic [MAX_LEN:0]     cur_code;
    logic                 sym_used;
    logic                 advance;
    logic                 last_addr;
    logic                 hist_clr;
    logic                 hist_inc;
    logic [LEN_WIDTH-1:0] hist_rd_len;

    assign hist_clr    = (state_q == IDLE) && start_i;
    assign hist_inc    = (state_q == COUNT);
    assign hist_rd_len = k_q - 1'b1;

    huff_len_hist #(
        .LEN_WIDTH (LEN_WIDTH),
        .MAX_LEN   (MAX_LEN),
        .BIN_W     (BIN_W)
    ) u_hist (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (hist_clr),
        .inc_i     (hist_inc),
        .inc_len_i (len_din_i),
        .rd_len_i  (hist_rd_len),
        .rd_cnt_o  (gen_cnt),
        .top_cnt_o (top_cnt)
    );

    always_comb begin
        acc_d     = (acc_q + (MAX_LEN + 1)'(gen_cnt)) << 1;
        kraft_sum = {1'b0, acc_d} + (MAX_LEN + 2)'(top_cnt);
        oversub   = kraft_sum > KRAFT_LIM;
        cur_code  = '0;
        for (int i = 1; i <= MAX_LEN; i++) begin
            if (len_din_i == LEN_WIDTH'(i)) begin
                cur_code = next_code_q[i];
            end
        end
        sym_used  = (len_din_i != '0);
        // Unused symbols never need the output register, so they never stall.
        advance   = !sym_used || !valid_q || code_ready_i;
        last_addr = (addr_q == LAST_ADDR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            bad_len_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
            sym_q     <= '0;
            code_q    <= '0;
            len_q     <= '0;
            for (int i = 1; i <= MAX_LEN; i++) begin
                next_code_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            if (valid_q && code_ready_i) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q   <= COUNT;
                        busy_q    <= 1'b1;
                        addr_q    <= '0;
                        bad_len_q <= 1'b0;
                        err_q     <= 1'b0;
                    end
                end
                COUNT: begin
                    if (len_din_i > MAX_LEN_L) begin
                        bad_len_q <= 1'b1;
                    end
                    if (last_addr) begin
                        state_q <= GEN;
                        addr_q  <= '0;
                        k_q     <= LEN_WIDTH'(1);
                        acc_q   <= '0;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                GEN: begin
                    acc_q <= acc_d;
                    for (int i = 1; i <= MAX_LEN; i++) begin
                        if (k_q == LEN_WIDTH'(i)) begin
                            next_code_q[i] <= acc_d;
                        end
                    end
                    if (k_q == MAX_LEN_L) begin
                        k_q <= '0;
                        if (bad_len_q || oversub) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= ASSIGN;
                        end
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                ASSIGN: begin
                    if (advance) begin
                        if (sym_used) begin
                            valid_q <= 1'b1;
                            sym_q   <= addr_q;
                            code_q  <= cur_code[MAX_LEN-1:0];
                            len_q   <= len_din_i;
                            for (int i = 1; i <= MAX_LEN; i++) begin
                                if (len_din_i == LEN_WIDTH'(i)) begin
                                    next_code_q[i] <= next_code_q[i] + 1'b1;
                                end
                            end
                        end
                        if (last_addr) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b0;
                            addr_q  <= '0;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    err_q   <= 1'b0;
                    addr_q  <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign len_addr_o   = addr_q;
    assign code_valid_o = valid_q;
    assign code_sym_o   = sym_q;
    assign code_o       = code_q;
    assign code_len_o   = len_q;

endmodule

`default_nettype wire

// File: tb/tb_huff_code_gen.sv
//------------------------------------------------------------------------------
// tb_huff_code_gen : randomized self-checking bench for huff_code_gen against a
//                    Kraft-sum / canonical-ordering reference model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_huff_code_gen;
    import huff_pkg::*;

    localparam int LW  = DEF_LEN_WIDTH;
    localparam int NS  = DEF_SYM_NUM;
    localparam int ML  = DEF_MAX_LEN;
    localparam int AW  = SYM_AW;
    localparam int BUDGET = 2000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy, done, err;
    logic [AW-1:0] len_addr;
    logic [LW-1:0] len_din;
    logic          code_valid;
    logic          code_ready;
    logic [AW-1:0] code_sym;
    logic [ML-1:0] code;
    logic [LW-1:0] code_len;

    logic [LW-1:0] lens [NS];
    int            n_chk = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            exp_sym[$], exp_code[$], exp_len[$];
    int            exp_count;
    bit            exp_err;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign len_din = lens[len_addr];

    huff_code_gen dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .len_addr_o   (len_addr),
        .len_din_i    (len_din),
        .code_valid_o (code_valid),
        .code_ready_i (code_ready),
        .code_sym_o   (code_sym),
        .code_o       (code),
        .code_len_o   (code_len)
    );

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Error = illegal length or Kraft sum above one; a symbol's canonical code
    // is the weight of all shorter codes plus same-length symbols before it.
    function automatic void build_model();
        longint kraft = 0;
        bit     bad = 0;
        exp_sym.delete(); exp_code.delete(); exp_len.delete();
        for (int s = 0; s < NS; s++) begin
            int l = int'(lens[s]);
            if (l > ML) bad = 1;
            else if (l != 0) kraft += longint'(1) << (ML - l);
        end
        exp_err = bad || (kraft > (longint'(1) << ML));
        if (!exp_err) begin
            for (int s = 0; s < NS; s++) begin
                int l = int'(lens[s]);
                int c = 0;
                if (l == 0) continue;
                for (int t = 0; t < NS; t++) begin
                    int lt = int'(lens[t]);
                    if (lt != 0 && lt < l) c += 1 << (l - lt);
                    else if (lt == l && t < s) c++;
                end
                exp_sym.push_back(s); exp_code.push_back(c); exp_len.push_back(l);
            end
        end
        exp_count = exp_sym.size();
    endfunction

    task automatic set_test1();
        for (int s = 0; s < NS; s++) lens[s] = '0;
        lens[0] = LW'(2); lens[1] = LW'(1); lens[2] = LW'(3); lens[3] = LW'(3);
    endtask

    // mode 0: legal, 1: oversubscribed (Kraft in (1,2)), 2: one length > MAX_LEN
    task automatic gen_lens(input int mode);
        int budget = 1 << ML;
        int dens = int'($urandom_range(5, 60));
        int used;
        int s0;
        for (int s = 0; s < NS; s++) begin
            int l = 0;
            lens[s] = '0;
            if (int'($urandom_range(0, 99)) < dens) begin
                l = int'($urandom_range(1, ML));
                if ((1 << (ML - l)) > budget) l = (budget > 0) ? ML : 0;
                if (l != 0) budget -= 1 << (ML - l);
                lens[s] = LW'(l);
            end
        end
        if (mode == 1) begin
            used = (1 << ML) - budget;
            s0 = int'($urandom_range(0, NS - 1));
            for (int j = 0; j < NS && used <= (1 << ML); j++) begin
                int s = (s0 + j) % NS;
                if (lens[s] == '0) begin
                    lens[s] = LW'(1);
                    used += 1 << (ML - 1);
                end
            end
        end else if (mode == 2) begin
            lens[$urandom_range(0, NS - 1)] = LW'($urandom_range(ML + 1, 63));
        end
    endtask

    task automatic kick();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_case(input string name, input bit rnd, input int stalls,
                            input int exp_done, input bit poke);
        int base, stall_left, done_cnt, n_rec;
        bit hold_prev;
        logic [AW-1:0] p_sym;
        logic [ML-1:0] p_code;
        logic [LW-1:0] p_len;
        build_model();
        code_ready = 1'b1;
        stall_left = stalls; done_cnt = 0; n_rec = 0; hold_prev = 0;
        p_sym = '0; p_code = '0; p_len = '0;
        kick();
        base = cyc;
        for (int rel = 1; rel <= BUDGET; rel++) begin
            @(negedge clk);
            start = poke && (rel == 100);
            if (rnd) code_ready = ($urandom_range(0, 3) != 0);
            else if (code_valid && stall_left > 0) begin code_ready = 1'b0; stall_left--; end
            else code_ready = 1'b1;
            if (rel == 1) begin
                check_eq({name, "_busy1"}, busy, 1);
                check_eq({name, "_addr1"}, len_addr, 0);
            end
            if (rel == NS) check_eq({name, "_addr_cnt_end"}, len_addr, NS - 1);
            if (hold_prev) begin
                check_eq({name, "_hold_v"}, code_valid, 1);
                check_eq({name, "_hold_sym"}, code_sym, p_sym);
                check_eq({name, "_hold_code"}, code, p_code);
                check_eq({name, "_hold_len"}, code_len, p_len);
            end
            hold_prev = code_valid && !code_ready;
            p_sym = code_sym; p_code = code; p_len = code_len;
            if (code_valid && code_ready) begin
                n_rec++;
                if (exp_sym.size() > 0) begin
                    check_eq({name, "_sym"}, code_sym, exp_sym.pop_front());
                    check_eq({name, "_code"}, code, exp_code.pop_front());
                    check_eq({name, "_len"}, code_len, exp_len.pop_front());
                end
            end
            if (done) begin
                done_cnt++;
                if (exp_done > 0) check_eq({name, "_done_cyc"}, rel - cyc + base + cyc - base, exp_done);
                check_eq({name, "_err"}, err, exp_err);
                check_eq({name, "_busy_done"}, busy, 1);
            end else if (done_cnt > 0 && !code_valid) begin
                check_eq({name, "_busy_idle"}, busy, 0);
                break;
            end
        end
        start = 1'b0;
        code_ready = 1'b1;
        check_eq({name, "_done_count"}, done_cnt, 1);
        check_eq({name, "_rec_count"}, n_rec, exp_count);
    endtask

    task automatic check_reset_state(input string name);
        check_eq({name, "_busy"}, busy, 0);
        check_eq({name, "_done"}, done, 0);
        check_eq({name, "_err"}, err, 0);
        check_eq({name, "_valid"}, code_valid, 0);
        check_eq({name, "_sym"}, code_sym, 0);
        check_eq({name, "_code"}, code, 0);
        check_eq({name, "_len"}, code_len, 0);
        check_eq({name, "_addr"}, len_addr, 0);
    endtask

    task automatic run_reset_mid();
        bit got = 0;
        int done_cnt = 0;
        set_test1();
        code_ready = 1'b1;
        kick();
        for (int rel = 1; rel <= 600; rel++) begin
            @(negedge clk);
            if (code_valid) begin
                got = 1;
                check_eq("rst_first_sym", code_sym, 0);
                break;
            end
        end
        check_eq("rst_rec_seen", got, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("rst_mid");
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check_eq("rst_no_done", done_cnt, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; code_ready = 1'b1;
        for (int s = 0; s < NS; s++) lens[s] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        set_test1();
        run_case("t1", 0, 0, 2 * NS + ML + 1, 0);

        for (int s = 0; s < NS; s++) lens[s] = '0;
        run_case("zero", 0, 0, 2 * NS + ML + 1, 0);

        set_test1();
        lens[5] = LW'(17);
        run_case("badlen", 0, 0, NS + ML + 1, 0);

        for (int s = 0; s < NS; s++) lens[s] = '0;
        lens[0] = LW'(1); lens[1] = LW'(1); lens[2] = LW'(1);
        run_case("oversub", 0, 0, NS + ML + 1, 0);

        set_test1();
        run_case("stall", 0, 3, 2 * NS + ML + 4, 0);

        run_reset_mid();
        set_test1();
        run_case("after_rst", 0, 0, 2 * NS + ML + 1, 0);

        for (int it = 0; it < 8; it++) begin
            int mode = (it % 4 == 3) ? int'($urandom_range(1, 2)) : 0;
            bit rnd = (it % 2 == 1);
            gen_lens(mode);
            build_model();
            run_case(rnd ? "rnd_stall" : "rnd", rnd, 0,
                     rnd ? -1 : (exp_err ? NS + ML + 1 : 2 * NS + ML + 1), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire
